mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one downstream memory port between the core's instruction-fetch requester (I) and data requester (D).
- Sits between core and memory/cache; one transaction outstanding at a time.
- Round-robin on contention; registered request and response paths.
- Optional watchdog flags a hung memory.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (instruction fetch returns low 32 bits in i_data)
TIMEOUT, 0, cycles to wait for m_ok before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_valid  in  1  fetch request; held until i_ok
i_addr  in  ADDR_W  fetch address
i_ok  out  1  one-cycle fetch completion pulse
i_data  out  32  fetched instruction; valid with i_ok
d_valid  in  1  data request; held until d_ok
d_addr  in  ADDR_W  data address
d_write  in  1  1 = store
d_size  in  3  access size code, passed through
d_strobe  in  DATA_W/8  byte strobes
d_wdata  in  DATA_W  store data
d_ok  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data; valid with d_ok
m_valid  out  1  downstream request valid
m_addr  out  ADDR_W  downstream address
m_write  out  1  downstream store flag
m_size  out  3  downstream size code
m_strobe  out  DATA_W/8  downstream strobes
m_wdata  out  DATA_W  downstream store data
m_ok  in  1  downstream completion; one cycle
m_rdata  in  DATA_W  downstream read data; valid with m_ok
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (reset low, async): state IDLE, prio = D, all outputs 0, latched request 0, timeout counter 0, timeout_err 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Grant evaluated combinationally from i_valid/d_valid; at most one winner.
  - A single requester wins outright.
  - If both are valid, the side named by prio wins.
  - On grant: latch the winner's addr/write/size/strobe/wdata; I grants force write = 0, size = word, strobe = 0.
  - Record the owner; set prio to the other side; go to BUSY.
  - If neither is valid, stay in IDLE.
- BUSY:
  - m_valid = 1; m_* driven from the latch and stable for the whole state.
  - On m_ok: capture m_rdata, go to RESP.
  - Counter increments every BUSY cycle. If TIMEOUT != 0 and the counter reaches TIMEOUT without m_ok: set timeout_err, capture rdata = 0, go to RESP.
- RESP:
  - Pulse ok to the owner for exactly one cycle; i_data = captured[31:0] or d_rdata = captured.
  - Pulse only if the owner's valid is still high this cycle. If valid has dropped (flush), the response is discarded silently and no ok is issued.
  - Always return to IDLE; counter cleared.
- Latency: request first seen in IDLE at cycle t → m_valid at t+1. m_ok at cycle k ≥ t+1 → ok at k+1. Next arbitration at k+2.
- Requester inputs change while BUSY: ignored; the latched copy is used.
- m_ok outside BUSY: ignored.
- Starvation-free: with both requesters continuously valid, grants strictly alternate.
- reset asserted mid-transaction: immediate return to IDLE; no ok pulse; m_valid drops asynchronously.
- timeout_err is cleared only by reset.
- i_ok and d_ok are never high in the same cycle.

Decomposition:
- Shared package: state enum (IDLE/BUSY/RESP), owner enum (OWN_I/OWN_D), latched-request struct {addr, write, size, strobe, wdata}, word-size code constant.
- One sub-module, rr_arbiter2: 2-way round-robin grant with prio register and update-on-grant input. Everything else lives in the top.

Test Plan:
- Single fetch: i_valid = 1, i_addr = 0x8000_0000; memory returns m_ok 3 cycles after m_valid with m_rdata = 0x0000_0000_0013_0513 → m_addr = 0x8000_0000 and m_write = 0; i_ok pulses 1 cycle with i_data = 0x00130513; d_ok stays 0.
- Contention after reset: i_valid and d_valid both high in the same cycle, d_write = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, strobe = 0xFF → D granted first with m_write = 1 and m_wdata = 0xDEADBEEF; I granted at the next IDLE. With both held high, grants alternate D,I,D,I for 8 transactions.
- Flush: I granted, i_valid drops during BUSY, m_ok later → no i_ok pulse; FSM back to IDLE; a subsequent D request proceeds normally.
- Input instability: change d_addr from 0x100 to 0x200 while BUSY → m_addr remains 0x100 until m_ok.
- Watchdog: TIMEOUT = 16, m_ok never asserted → timeout_err = 1 after 16 BUSY cycles; owner receives ok with data 0; timeout_err stays set until reset.
- Async reset: assert reset low mid-BUSY between clock edges → m_valid = 0 immediately, no ok pulses; after release the first contention grants D.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states, owner tags and
// the latched downstream request.
package mem_bus_arbiter_pkg;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Size code forced onto every instruction fetch.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [MAX_STRB_W-1:0] strobe;
        logic [MAX_DATA_W-1:0] wdata;
    } req_t;

    function automatic owner_e other_side(input owner_e o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();

    logic                  i_valid;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ok;
    logic [31:0]           i_data;

    logic                  d_valid;
    logic [ADDR_W-1:0]     d_addr;
    logic                  d_write;
    logic [2:0]            d_size;
    logic [DATA_W/8-1:0]   d_strobe;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_ok;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_valid;
    logic [ADDR_W-1:0]     m_addr;
    logic                  m_write;
    logic [2:0]            m_size;
    logic [DATA_W/8-1:0]   m_strobe;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_ok;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ok, i_data,
        input  d_valid, d_addr, d_write, d_size, d_strobe, d_wdata,
        output d_ok, d_rdata,
        output m_valid, m_addr, m_write, m_size, m_strobe, m_wdata,
        input  m_ok, m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ok, i_data,
        output d_valid, d_addr, d_write, d_size, d_strobe, d_wdata,
        input  d_ok, d_rdata,
        input  m_valid, m_addr, m_write, m_size, m_strobe, m_wdata,
        output m_ok, m_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, on contention the side
// named by prio wins and prio flips to the loser when update is pulsed.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,     // [0] = I, [1] = D
    input  logic       update,
    output logic [1:0] gnt
);

    owner_e prio_r;

    // Combinational one-hot grant selection.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio_r == OWN_D) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Priority register; D is favoured out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= OWN_D;
        end else if (update) begin
            prio_r <= other_side(gnt[1] ? OWN_D : OWN_I);
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between instruction fetch (I) and data (D)
// requesters; one transaction in flight, round-robin on contention, optional watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output logic               timeout_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit WD_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e             state_r;
    state_e             state_s;
    owner_e             owner_r;
    req_t               req_r;
    req_t               req_s;
    logic [1:0]         req_vec_s;
    logic [1:0]         gnt_s;
    logic               grant_s;
    logic               capture_s;
    logic               timeout_hit_s;
    logic [DATA_W-1:0]  cap_data_s;
    logic               m_valid_r;
    logic               resp_i_r;
    logic               resp_d_r;
    logic [31:0]        i_data_r;
    logic [DATA_W-1:0]  d_rdata_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               timeout_err_r;

    assign req_vec_s = {bus.d_valid, bus.i_valid};

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vec_s),
        .update (grant_s),
        .gnt    (gnt_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, request latch selection and capture strobes.
    always_comb begin
        state_s       = state_r;
        req_s         = req_r;
        grant_s       = 1'b0;
        capture_s     = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    grant_s = 1'b1;
                    state_s = ST_BUSY;
                    req_s   = '0;
                    if (gnt_s[1]) begin
                        req_s.addr[ADDR_W-1:0]   = bus.d_addr;
                        req_s.write              = bus.d_write;
                        req_s.size               = bus.d_size;
                        req_s.strobe[STRB_W-1:0] = bus.d_strobe;
                        req_s.wdata[DATA_W-1:0]  = bus.d_wdata;
                    end else begin
                        // Fetches are always word reads with no strobes.
                        req_s.addr[ADDR_W-1:0]   = bus.i_addr;
                        req_s.write              = 1'b0;
                        req_s.size               = SIZE_WORD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.m_ok) begin
                    capture_s = 1'b1;
                    state_s   = ST_RESP;
                end else if (WD_EN && (cnt_r == TO_LAST)) begin
                    capture_s     = 1'b1;
                    timeout_hit_s = 1'b1;
                    state_s       = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (timeout_hit_s) begin
            cap_data_s = '0;
        end else begin
            cap_data_s = bus.m_rdata;
        end
    end

    // Datapath: request latch, owner, response capture, watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_r         <= '0;
            owner_r       <= OWN_I;
            m_valid_r     <= 1'b0;
            resp_i_r      <= 1'b0;
            resp_d_r      <= 1'b0;
            i_data_r      <= 32'h0000_0000;
            d_rdata_r     <= '0;
            cnt_r         <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            req_r <= req_s;
            if (grant_s) begin
                owner_r   <= gnt_s[1] ? OWN_D : OWN_I;
                m_valid_r <= 1'b1;
            end else if (capture_s) begin
                m_valid_r <= 1'b0;
            end
            resp_i_r <= capture_s && (owner_r == OWN_I);
            resp_d_r <= capture_s && (owner_r == OWN_D);
            if (capture_s && (owner_r == OWN_I)) begin
                i_data_r <= cap_data_s[31:0];
            end
            if (capture_s && (owner_r == OWN_D)) begin
                d_rdata_r <= cap_data_s;
            end
            if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    // A requester that dropped valid before the response is treated as flushed.
    assign bus.i_ok    = resp_i_r & bus.i_valid;
    assign bus.d_ok    = resp_d_r & bus.d_valid;
    assign bus.i_data  = i_data_r;
    assign bus.d_rdata = d_rdata_r;

    assign bus.m_valid  = m_valid_r;
    assign bus.m_addr   = req_r.addr[ADDR_W-1:0];
    assign bus.m_write  = req_r.write;
    assign bus.m_size   = req_r.size;
    assign bus.m_strobe = req_r.strobe[STRB_W-1:0];
    assign bus.m_wdata  = req_r.wdata[DATA_W-1:0];

    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected downstream
// requests and responses, independent monitors pop and compare them.
module tb_mem_bus_arbiter;

    logic clk;
    logic reset;
    logic timeout_err;

    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [63:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } exp_req_t;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
    } exp_rsp_t;

    exp_req_t exp_req_q[$];
    exp_rsp_t exp_rsp_q[$];

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;
    int i_ok_cnt = 0;
    int last_busy_len = 0;
    int busy_len = 0;
    logic mv_prev = 1'b0;
    logic unstable = 1'b0;
    logic [63:0] cur_addr = 64'h0;
    logic [63:0] cur_wdata = 64'h0;

    // memory model controls
    int mem_lat = 1;
    logic mem_hang = 1'b0;
    logic [63:0] mem_rdata = 64'h0;
    int lat_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_i(input logic [63:0] addr, input logic [63:0] data);
        exp_req_t r;
        exp_rsp_t s;
        r.addr = addr; r.write = 1'b0; r.size = 3'd2; r.strobe = 8'h00; r.wdata = 64'h0;
        s.is_d = 1'b0; s.data = data;
        exp_req_q.push_back(r);
        exp_rsp_q.push_back(s);
    endtask

    task automatic push_d_req(input logic [63:0] addr, input logic w, input logic [2:0] size,
                              input logic [7:0] strb, input logic [63:0] wdata);
        exp_req_t r;
        r.addr = addr; r.write = w; r.size = size; r.strobe = strb; r.wdata = wdata;
        exp_req_q.push_back(r);
    endtask

    task automatic push_d_rsp(input logic [63:0] data);
        exp_rsp_t s;
        s.is_d = 1'b1; s.data = data;
        exp_rsp_q.push_back(s);
    endtask

    task automatic set_d(input logic [63:0] addr, input logic w, input logic [63:0] wdata);
        bus.d_addr = addr; bus.d_write = w; bus.d_size = 3'd3;
        bus.d_strobe = 8'hFF; bus.d_wdata = wdata;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_seen < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_wait", 64'(rsp_seen >= target), 64'h1);
    endtask

    // Memory responder: m_ok mem_lat cycles after m_valid first appears.
    always @(negedge clk) begin
        if (bus.m_ok) begin
            bus.m_ok = 1'b0;
        end else if (bus.m_valid && !mem_hang) begin
            if (lat_cnt >= mem_lat) begin
                bus.m_ok = 1'b1;
                lat_cnt = 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
        bus.m_rdata = mem_rdata;
    end

    // Request monitor: checks each new downstream request and its stability.
    always @(negedge clk) begin
        exp_req_t e;
        if (bus.m_valid && !mv_prev) begin
            if (exp_req_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_req: actual=%0h required=none", bus.m_addr);
            end else begin
                e = exp_req_q.pop_front();
                chk("req_addr", bus.m_addr, e.addr);
                chk("req_write", 64'(bus.m_write), 64'(e.write));
                chk("req_size", 64'(bus.m_size), 64'(e.size));
                chk("req_strobe", 64'(bus.m_strobe), 64'(e.strobe));
                chk("req_wdata", bus.m_wdata, e.wdata);
            end
            cur_addr = bus.m_addr;
            cur_wdata = bus.m_wdata;
            unstable = 1'b0;
            busy_len = 1;
        end else if (bus.m_valid) begin
            busy_len++;
            if (bus.m_addr !== cur_addr || bus.m_wdata !== cur_wdata) unstable = 1'b1;
        end
        if (!bus.m_valid && mv_prev) begin
            chk("req_stable", 64'(unstable), 64'h0);
            last_busy_len = busy_len;
        end
        mv_prev = bus.m_valid;
    end

    // Response monitor: pops expected completions on every ok pulse.
    always @(negedge clk) begin
        exp_rsp_t e;
        if (bus.i_ok || bus.d_ok) begin
            chk("ok_exclusive", 64'(bus.i_ok & bus.d_ok), 64'h0);
            if (exp_rsp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ok: actual=i%0b/d%0b required=none", bus.i_ok, bus.d_ok);
            end else begin
                e = exp_rsp_q.pop_front();
                chk("rsp_side", 64'(bus.d_ok), 64'(e.is_d));
                chk("rsp_data", e.is_d ? bus.d_rdata : {32'h0, bus.i_data}, e.data);
            end
            rsp_seen++;
            if (bus.i_ok) i_ok_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int snap;
        reset = 1'b0;
        bus.i_valid = 1'b0; bus.i_addr = 64'h0;
        bus.d_valid = 1'b0; set_d(64'h0, 1'b0, 64'h0); bus.d_strobe = 8'h00;
        bus.m_ok = 1'b0; bus.m_rdata = 64'h0;
        @(negedge clk);
        chk("rst_m_valid", 64'(bus.m_valid), 64'h0);
        chk("rst_i_ok", 64'(bus.i_ok), 64'h0);
        chk("rst_d_ok", 64'(bus.d_ok), 64'h0);
        chk("rst_timeout_err", 64'(timeout_err), 64'h0);
        chk("rst_m_addr", bus.m_addr, 64'h0);
        @(posedge clk); #1 reset = 1'b1;

        // single fetch, memory answers 3 cycles after m_valid
        mem_lat = 3; mem_rdata = 64'h0000_0000_0013_0513;
        push_i(64'h8000_0000, 64'h0000_0000_0013_0513);
        @(posedge clk); #1;
        bus.i_addr = 64'h8000_0000; bus.i_valid = 1'b1;
        @(negedge clk); chk("fetch_mvalid_t", 64'(bus.m_valid), 64'h0);
        @(negedge clk); chk("fetch_mvalid_t1", 64'(bus.m_valid), 64'h1);
        wait_rsp(1);
        bus.i_valid = 1'b0;
        chk("fetch_busy_len", 64'(last_busy_len), 64'd4);

        // contention after reset: D first, then strict alternation
        reset = 1'b0; repeat (2) @(posedge clk); #1 reset = 1'b1;
        mem_lat = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                push_d_req(64'h100, 1'b1, 3'd3, 8'hFF, 64'h0000_0000_DEAD_BEEF);
                push_d_rsp(64'h0123_4567_89AB_CDEF);
            end else begin
                push_i(64'h8000_0004, 64'h0000_0000_89AB_CDEF);
            end
        end
        base = rsp_seen;
        set_d(64'h100, 1'b1, 64'h0000_0000_DEAD_BEEF);
        bus.i_addr = 64'h8000_0004;
        bus.d_valid = 1'b1; bus.i_valid = 1'b1;
        wait_rsp(base + 8);
        bus.d_valid = 1'b0; bus.i_valid = 1'b0;

        // flush: fetch withdrawn during BUSY, then a normal D load
        mem_lat = 4; mem_rdata = 64'hFFFF_0000_1234_5678;
        push_d_req(64'h8000_0010, 1'b0, 3'd2, 8'h00, 64'h0);
        snap = i_ok_cnt;
        @(posedge clk); #1;
        bus.i_addr = 64'h8000_0010; bus.i_valid = 1'b1;
        repeat (2) @(posedge clk); #1 bus.i_valid = 1'b0;
        repeat (8) @(posedge clk); #1;
        chk("flush_no_iok", 64'(i_ok_cnt), 64'(snap));
        push_d_req(64'h40, 1'b0, 3'd3, 8'hFF, 64'h0);
        push_d_rsp(64'hFFFF_0000_1234_5678);
        base = rsp_seen;
        set_d(64'h40, 1'b0, 64'h0);
        bus.d_valid = 1'b1;
        wait_rsp(base + 1);
        bus.d_valid = 1'b0;

        // input instability: d_addr changes while BUSY
        mem_lat = 5; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        push_d_req(64'h100, 1'b0, 3'd3, 8'hFF, 64'h0);
        push_d_rsp(64'hAAAA_BBBB_CCCC_DDDD);
        base = rsp_seen;
        set_d(64'h100, 1'b0, 64'h0);
        bus.d_valid = 1'b1;
        repeat (2) @(posedge clk); #1 bus.d_addr = 64'h200;
        @(negedge clk); chk("instab_addr", bus.m_addr, 64'h100);
        wait_rsp(base + 1);
        bus.d_valid = 1'b0;

        // watchdog: memory never answers
        chk("wd_err_clear", 64'(timeout_err), 64'h0);
        mem_hang = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
        push_d_req(64'h300, 1'b0, 3'd3, 8'hFF, 64'h0);
        push_d_rsp(64'h0);
        base = rsp_seen;
        set_d(64'h300, 1'b0, 64'h0);
        bus.d_valid = 1'b1;
        wait_rsp(base + 1);
        bus.d_valid = 1'b0;
        chk("wd_err_set", 64'(timeout_err), 64'h1);
        chk("wd_busy_len", 64'(last_busy_len), 64'd16);
        mem_hang = 1'b0; mem_lat = 2; mem_rdata = 64'h0000_0000_0000_0073;
        push_i(64'h8000_0040, 64'h0000_0000_0000_0073);
        base = rsp_seen;
        bus.i_addr = 64'h8000_0040; bus.i_valid = 1'b1;
        wait_rsp(base + 1);
        bus.i_valid = 1'b0;
        chk("wd_err_sticky", 64'(timeout_err), 64'h1);

        // async reset in the middle of BUSY
        mem_hang = 1'b1;
        push_d_req(64'h400, 1'b0, 3'd3, 8'hFF, 64'h0);
        set_d(64'h400, 1'b0, 64'h0);
        bus.d_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("areset_busy", 64'(bus.m_valid), 64'h1);
        #1 reset = 1'b0;
        #1 chk("areset_mvalid", 64'(bus.m_valid), 64'h0);
        bus.d_valid = 1'b0;
        snap = rsp_seen;
        repeat (2) @(posedge clk); #1 reset = 1'b1;
        mem_hang = 1'b0;
        chk("areset_no_ok", 64'(rsp_seen), 64'(snap));
        chk("areset_err_clr", 64'(timeout_err), 64'h0);

        // first contention after reset must grant D
        mem_lat = 1; mem_rdata = 64'h1357_9BDF_2468_ACE0;
        push_d_req(64'h500, 1'b0, 3'd3, 8'hFF, 64'h0);
        push_d_rsp(64'h1357_9BDF_2468_ACE0);
        push_i(64'h8000_0020, 64'h0000_0000_2468_ACE0);
        base = rsp_seen;
        set_d(64'h500, 1'b0, 64'h0);
        bus.i_addr = 64'h8000_0020;
        bus.d_valid = 1'b1; bus.i_valid = 1'b1;
        wait_rsp(base + 1);
        bus.d_valid = 1'b0;
        wait_rsp(base + 2);
        bus.i_valid = 1'b0;

        repeat (4) @(posedge clk); #1;
        chk("req_q_empty", 64'(exp_req_q.size()), 64'h0);
        chk("rsp_q_empty", 64'(exp_rsp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
